// File: rtl/pixel_layer_arbiter_if.sv
// rtl/pixel_layer_arbiter_if.sv - pixel/layer bus between the video timing source and the layer arbiter
interface pixel_layer_arbiter_if;
  logic       pix_valid_in;
  logic       video_on;
  logic       frame_start;
  logic [4:0] hud_cl;
  logic [4:0] bul_cl;
  logic [4:0] ship_cl;
  logic [4:0] ast_cl;
  logic       ship_blink;
  logic [4:0] cl_frm_log;
  logic       pix_valid_out;
  logic [1:0] layer_id;
  logic       coll_ship;
  logic       coll_bullet;

  // Pixel source side
  modport master (
    output pix_valid_in, video_on, frame_start,
    output hud_cl, bul_cl, ship_cl, ast_cl, ship_blink,
    input  cl_frm_log, pix_valid_out, layer_id, coll_ship, coll_bullet
  );

  // Arbiter side
  modport slave (
    input  pix_valid_in, video_on, frame_start,
    input  hud_cl, bul_cl, ship_cl, ast_cl, ship_blink,
    output cl_frm_log, pix_valid_out, layer_id, coll_ship, coll_bullet
  );
endinterface

// File: rtl/pixel_layer_arbiter.sv
// rtl/pixel_layer_arbiter.sv - two-stage sprite layer priority compositor with frame collision flags (optional ship blink: SHIP_BLINK_EN)
module pixel_layer_arbiter #(
  parameter logic [4:0] BG_CODE    = 5'b00000,
  parameter int         BLINK_HALF = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pixel_layer_arbiter_if.slave        bus
);

  logic       w_ship_mask;

`ifdef SHIP_BLINK_EN
  localparam logic [8:0] L_WRAP = 9'(2 * BLINK_HALF - 1);
  localparam logic [8:0] L_HALF = 9'(BLINK_HALF);

  logic [7:0] r_frm_cnt;

  // Frame counter: advances per frame, wraps after a full blink period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_cnt <= 8'd0;
    end else if (bus.frame_start) begin
      if ({1'b0, r_frm_cnt} == L_WRAP) r_frm_cnt <= 8'd0;
      else                             r_frm_cnt <= r_frm_cnt + 8'd1;
    end
  end

  assign w_ship_mask = bus.ship_blink && ({1'b0, r_frm_cnt} >= L_HALF);
`else
  logic w_unused_blink;
  assign w_ship_mask    = 1'b0;
  assign w_unused_blink = ^{bus.ship_blink, BLINK_HALF[7:0]};
`endif

  logic       r_s1_valid;
  logic [4:0] r_s1_hud;
  logic [4:0] r_s1_bul;
  logic [4:0] r_s1_ship;
  logic [4:0] r_s1_ast;

  // Stage 1: capture layer codes; blanking and ship mask turn layers empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hud   <= BG_CODE;
      r_s1_bul   <= BG_CODE;
      r_s1_ship  <= BG_CODE;
      r_s1_ast   <= BG_CODE;
    end else begin
      r_s1_valid <= bus.pix_valid_in;
      if (bus.pix_valid_in) begin
        r_s1_hud  <= bus.video_on ? bus.hud_cl : BG_CODE;
        r_s1_bul  <= bus.video_on ? bus.bul_cl : BG_CODE;
        r_s1_ship <= (bus.video_on && !w_ship_mask) ? bus.ship_cl : BG_CODE;
        r_s1_ast  <= bus.video_on ? bus.ast_cl : BG_CODE;
      end
    end
  end

  logic [4:0] w_win_cl;
  logic [1:0] w_win_id;

  // Fixed priority select: HUD over bullet over ship over asteroid
  always_comb begin
    w_win_cl = BG_CODE;
    w_win_id = 2'd0;
    if (r_s1_hud != BG_CODE) begin
      w_win_cl = r_s1_hud;
      w_win_id = 2'd3;
    end else if (r_s1_bul != BG_CODE) begin
      w_win_cl = r_s1_bul;
      w_win_id = 2'd2;
    end else if (r_s1_ship != BG_CODE) begin
      w_win_cl = r_s1_ship;
      w_win_id = 2'd1;
    end else if (r_s1_ast != BG_CODE) begin
      w_win_cl = r_s1_ast;
      w_win_id = 2'd0;
    end
  end

  // Stage 2: register the winner only for a real pixel so outputs hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cl_frm_log    <= BG_CODE;
      bus.layer_id      <= 2'd0;
      bus.pix_valid_out <= 1'b0;
    end else begin
      bus.pix_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        bus.cl_frm_log <= w_win_cl;
        bus.layer_id   <= w_win_id;
      end
    end
  end

  // Overlap is judged on raw layer presence, independent of who won priority
  logic w_hit_ship;
  logic w_hit_bul;
  assign w_hit_ship = r_s1_valid && (r_s1_ship != BG_CODE) && (r_s1_ast != BG_CODE);
  assign w_hit_bul  = r_s1_valid && (r_s1_bul  != BG_CODE) && (r_s1_ast != BG_CODE);

  logic r_acc_ship;
  logic r_acc_bul;

  // Collision accumulators; a frame boundary publishes them, including the pixel at the boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_ship      <= 1'b0;
      r_acc_bul       <= 1'b0;
      bus.coll_ship   <= 1'b0;
      bus.coll_bullet <= 1'b0;
    end else if (bus.frame_start) begin
      bus.coll_ship   <= r_acc_ship | w_hit_ship;
      bus.coll_bullet <= r_acc_bul  | w_hit_bul;
      r_acc_ship      <= 1'b0;
      r_acc_bul       <= 1'b0;
    end else begin
      r_acc_ship <= r_acc_ship | w_hit_ship;
      r_acc_bul  <= r_acc_bul  | w_hit_bul;
    end
  end

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// tb/tb_pixel_layer_arbiter.sv - vector table and scoreboard bench for pixel_layer_arbiter
module tb_pixel_layer_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_layer_arbiter_if bus ();

  pixel_layer_arbiter #(.BG_CODE(5'b00000), .BLINK_HALF(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] hud;
    logic [4:0] bul;
    logic [4:0] ship;
    logic [4:0] ast;
    logic       vid;
    logic [4:0] exp_cl;
    logic [1:0] exp_id;
  } vec_t;

  typedef struct {
    logic [4:0] cl;
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every output pixel must match the oldest expectation, two cycles after its strobe
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.pix_valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_pix_valid_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("cl_frm_log", 32'(bus.cl_frm_log), 32'(e.cl));
        chk("layer_id", 32'(bus.layer_id), 32'(e.id));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send(input logic [4:0] h, input logic [4:0] b, input logic [4:0] s,
                      input logic [4:0] a, input logic v, input logic fs,
                      input logic [4:0] ecl, input logic [1:0] eid);
    exp_t e;
    @(posedge clk); #1;
    bus.hud_cl = h; bus.bul_cl = b; bus.ship_cl = s; bus.ast_cl = a;
    bus.video_on = v; bus.frame_start = fs; bus.pix_valid_in = 1'b1;
    e.cl = ecl; e.id = eid; e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.pix_valid_in = 1'b0;
      bus.frame_start  = 1'b0;
    end
  endtask

  task automatic frame_pulse();
    @(posedge clk); #1;
    bus.pix_valid_in = 1'b0;
    bus.frame_start  = 1'b1;
    @(posedge clk); #1;
    bus.frame_start  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      idle(1);
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_coll(input string name, input logic ship, input logic bul);
    @(negedge clk);
    chk({name, "_coll_ship"}, 32'(bus.coll_ship), 32'(ship));
    chk({name, "_coll_bullet"}, 32'(bus.coll_bullet), 32'(bul));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_cl"}, 32'(bus.cl_frm_log), 32'd0);
    chk({name, "_id"}, 32'(bus.layer_id), 32'd0);
    chk({name, "_valid"}, 32'(bus.pix_valid_out), 32'd0);
    chk({name, "_coll_ship"}, 32'(bus.coll_ship), 32'd0);
    chk({name, "_coll_bullet"}, 32'(bus.coll_bullet), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5'h00, 5'h00, 5'h0E, 5'h07, 1'b1, 5'h0E, 2'd1};
    vecs[1] = '{5'h1F, 5'h03, 5'h0E, 5'h07, 1'b1, 5'h1F, 2'd3};
    vecs[2] = '{5'h1F, 5'h03, 5'h0E, 5'h07, 1'b0, 5'h00, 2'd0};
    vecs[3] = '{5'h00, 5'h12, 5'h0E, 5'h07, 1'b1, 5'h12, 2'd2};
    vecs[4] = '{5'h00, 5'h00, 5'h00, 5'h15, 1'b1, 5'h15, 2'd0};
    vecs[5] = '{5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 5'h00, 2'd0};
    vecs[6] = '{5'h01, 5'h00, 5'h00, 5'h00, 1'b1, 5'h01, 2'd3};

    bus.pix_valid_in = 1'b0; bus.video_on = 1'b0; bus.frame_start = 1'b0;
    bus.hud_cl = '0; bus.bul_cl = '0; bus.ship_cl = '0; bus.ast_cl = '0;
    bus.ship_blink = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      send(vecs[i].hud, vecs[i].bul, vecs[i].ship, vecs[i].ast, vecs[i].vid, 1'b0,
           vecs[i].exp_cl, vecs[i].exp_id);
    idle(1);
    drain();

    for (int i = 6; i >= 0; i--) begin
      send(vecs[i].hud, vecs[i].bul, vecs[i].ship, vecs[i].ast, vecs[i].vid, 1'b0,
           vecs[i].exp_cl, vecs[i].exp_id);
      idle(1 + (i % 2));
    end
    drain();

    frame_pulse();
    frame_pulse();
    chk_coll("clean_frame", 1'b0, 1'b0);

    send(5'h00, 5'h00, 5'h01, 5'h0A, 1'b1, 1'b0, 5'h01, 2'd1);
    idle(4);
    frame_pulse();
    chk_coll("ship_hit", 1'b1, 1'b0);
    idle(3);
    chk_coll("ship_hit_hold", 1'b1, 1'b0);
    frame_pulse();
    chk_coll("after_clean", 1'b0, 1'b0);

    send(5'h00, 5'h03, 5'h00, 5'h04, 1'b1, 1'b0, 5'h03, 2'd2);
    frame_pulse();
    chk_coll("bul_at_boundary", 1'b0, 1'b1);
    frame_pulse();
    chk_coll("bul_cleared", 1'b0, 1'b0);

    send(5'h00, 5'h03, 5'h00, 5'h04, 1'b1, 1'b1, 5'h03, 2'd2);
    idle(1);
    chk_coll("coincident_first", 1'b0, 1'b0);
    frame_pulse();
    chk_coll("coincident_second", 1'b0, 1'b1);
    drain();

    send(5'h00, 5'h00, 5'h01, 5'h0A, 1'b1, 1'b0, 5'h01, 2'd1);
    idle(2);
    frame_pulse();
    chk_coll("pre_reset", 1'b1, 1'b0);
    drain();
    send(5'h00, 5'h00, 5'h0E, 5'h00, 1'b1, 1'b0, 5'h0E, 2'd1);
    send(5'h00, 5'h12, 5'h00, 5'h00, 1'b1, 1'b0, 5'h12, 2'd2);
    @(posedge clk); #3;
    bus.pix_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);
    send(5'h00, 5'h00, 5'h00, 5'h15, 1'b1, 1'b0, 5'h15, 2'd0);
    idle(1);
    drain();

`ifdef SHIP_BLINK_EN
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ship_blink = 1'b1;
    for (int f = 0; f < 6; f++) begin
      if ((f % 4) < 2) send(5'h00, 5'h00, 5'h0E, 5'h07, 1'b1, 1'b0, 5'h0E, 2'd1);
      else             send(5'h00, 5'h00, 5'h0E, 5'h07, 1'b1, 1'b0, 5'h07, 2'd0);
      idle(1);
      drain();
      frame_pulse();
      chk_coll("blink_frame", ((f % 4) < 2) ? 1'b1 : 1'b0, 1'b0);
    end
    bus.ship_blink = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
